bin_to_bcd_seq: RTL and testbench

Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It is the successor to the single-cycle divide/modulo lookup converter that feeds the distance display path. It trades latency for area, takes arbitrary input width and digit count, and adds a start/ready/done handshake and a saturating overflow flag.

---
 rtl/bin_to_bcd_seq.sv | 120 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// start/ready/done handshake; saturates to all 9s with a sticky overflow flag
// when the operand does not fit in DIGITS decimal digits.
// Optional feature macro: LEADING_ZERO_BLANK_EN adds a registered 'blank'
// output marking leading-zero digits.
module bin_to_bcd_seq #(
   parameter int unsigned IN_W   = 16,
   parameter int unsigned DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [IN_W-1:0]       val,
   output logic                  ready,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
`ifdef LEADING_ZERO_BLANK_EN
   ,
   output logic [DIGITS-1:0]     blank
`endif
);

   localparam int unsigned BW    = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(IN_W);
   localparam logic [BW-1:0] SAT_NINES = {DIGITS{4'h9}};

   typedef enum logic {StIdle, StConv} state_t;

   state_t             state;
   logic [BW-1:0]      scratch;
   logic [IN_W-1:0]    operand;
   logic [CNT_W-1:0]   cnt;
   logic               sticky;

   logic [BW-1:0]      adj;
   logic [BW-1:0]      shifted;
   logic               sticky_nxt;
   logic [BW-1:0]      final_bcd;

   // One double-dabble step: add 3 to digits >= 5, then shift in the operand MSB
   always_comb begin
      adj = scratch;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (scratch[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
         end
      end
      shifted    = {adj[BW-2:0], operand[IN_W-1]};
      // A 1 leaving the top digit means the running value reached 10^DIGITS
      sticky_nxt = sticky | adj[BW-1];
      final_bcd  = sticky_nxt ? SAT_NINES : shifted;
   end

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;
   logic [DIGITS-1:0] blank_nxt;
   logic              zero_above;

   // Digit i is blank when it and every higher digit are zero; units never blank
   always_comb begin
      blank_nxt  = '0;
      zero_above = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         zero_above   = zero_above & (final_bcd[4*i +: 4] == 4'd0);
         blank_nxt[i] = zero_above;
      end
      blank_nxt[0] = 1'b0;
   end
`endif

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= StIdle;
         ready    <= 1'b1;
         done     <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
         scratch  <= '0;
         operand  <= '0;
         cnt      <= '0;
         sticky   <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
         blank    <= BLANK_RST;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  operand <= val;
                  scratch <= '0;
                  sticky  <= 1'b0;
                  cnt     <= CNT_W'(IN_W - 1);
                  ready   <= 1'b0;
                  state   <= StConv;
               end
            end
            StConv: begin
               scratch <= shifted;
               operand <= {operand[IN_W-2:0], 1'b0};
               sticky  <= sticky_nxt;
               cnt     <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  state    <= StIdle;
                  ready    <= 1'b1;
                  done     <= 1'b1;
                  bcd      <= final_bcd;
                  overflow <= sticky_nxt;
`ifdef LEADING_ZERO_BLANK_EN
                  blank    <= blank_nxt;
`endif
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: three instances (16/5, 16/4, 8/3),
// directed handshake/overflow/reset cases and a randomised sweep compared
// against a decimal reference model.
module tb_bin_to_bcd_seq;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   logic        a_start = 1'b0;
   logic [15:0] a_val   = '0;
   logic        a_ready, a_done, a_ovf;
   logic [19:0] a_bcd;
   logic [4:0]  a_blank;

   logic        b_start = 1'b0;
   logic [15:0] b_val   = '0;
   logic        b_ready, b_done, b_ovf;
   logic [15:0] b_bcd;
   logic [3:0]  b_blank;

   logic        c_start = 1'b0;
   logic [7:0]  c_val   = '0;
   logic        c_ready, c_done, c_ovf;
   logic [11:0] c_bcd;
   logic [2:0]  c_blank;

   int checks = 0;
   int errors = 0;
   int lat;

   bin_to_bcd_seq #(.IN_W(16), .DIGITS(5)) u_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .val(a_val), .ready(a_ready),
      .done(a_done), .bcd(a_bcd), .overflow(a_ovf)
`ifdef LEADING_ZERO_BLANK_EN
      , .blank(a_blank)
`endif
   );

   bin_to_bcd_seq #(.IN_W(16), .DIGITS(4)) u_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .val(b_val), .ready(b_ready),
      .done(b_done), .bcd(b_bcd), .overflow(b_ovf)
`ifdef LEADING_ZERO_BLANK_EN
      , .blank(b_blank)
`endif
   );

   bin_to_bcd_seq #(.IN_W(8), .DIGITS(3)) u_c (
      .clk(clk), .rst_n(rst_n), .start(c_start), .val(c_val), .ready(c_ready),
      .done(c_done), .bcd(c_bcd), .overflow(c_ovf)
`ifdef LEADING_ZERO_BLANK_EN
      , .blank(c_blank)
`endif
   );

   initial forever #5 clk = ~clk;

   function automatic longint unsigned pow10(input int d);
      longint unsigned p = 1;
      for (int i = 0; i < d; i++) p = p * 10;
      return p;
   endfunction

   // Decimal digits of v, or all 9s when v needs more than d digits
   function automatic logic [63:0] ref_bcd(input longint unsigned v, input int d);
      logic [63:0] r = '0;
      for (int i = 0; i < d; i++) begin
         if (v >= pow10(d)) r[4*i +: 4] = 4'd9;
         else               r[4*i +: 4] = 4'((v / pow10(i)) % 10);
      end
      return r;
   endfunction

   function automatic logic ref_ovf(input longint unsigned v, input int d);
      return v >= pow10(d);
   endfunction

   // Digit i (i>=1) blank exactly when v < 10^i; nothing blank on overflow
   function automatic logic [63:0] ref_blank(input longint unsigned v, input int d);
      logic [63:0] r = '0;
      if (v < pow10(d)) begin
         for (int i = 1; i < d; i++) r[i] = (v < pow10(i));
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with ready=1; returns at the negedge after the accepting edge
   task automatic start_a(input logic [15:0] v);
      a_val   = v;
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      a_val   = 16'($urandom);
   endtask

   task automatic wait_a(input int so_far, output int l);
      l = so_far;
      while (l < 40) begin
         @(negedge clk);
         l++;
         if (a_done) break;
      end
   endtask

   task automatic check_a(input string tag, input longint unsigned v, input int l);
      chk({tag, "_lat"},   64'(l), 64'd16);
      chk({tag, "_done"},  64'(a_done), 64'd1);
      chk({tag, "_bcd"},   64'(a_bcd), ref_bcd(v, 5));
      chk({tag, "_ovf"},   64'(a_ovf), 64'(ref_ovf(v, 5)));
      chk({tag, "_ready"}, 64'(a_ready), 64'd1);
`ifdef LEADING_ZERO_BLANK_EN
      chk({tag, "_blank"}, 64'(a_blank), ref_blank(v, 5));
`endif
   endtask

   task automatic conv_b(input string tag, input longint unsigned v);
      int l = 0;
      b_val   = 16'(v);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      while (l < 40) begin
         @(negedge clk);
         l++;
         if (b_done) break;
      end
      chk({tag, "_lat"}, 64'(l), 64'd16);
      chk({tag, "_bcd"}, 64'(b_bcd), ref_bcd(v, 4));
      chk({tag, "_ovf"}, 64'(b_ovf), 64'(ref_ovf(v, 4)));
`ifdef LEADING_ZERO_BLANK_EN
      chk({tag, "_blank"}, 64'(b_blank), ref_blank(v, 4));
`endif
   endtask

   task automatic conv_c(input string tag, input longint unsigned v);
      int l = 0;
      c_val   = 8'(v);
      c_start = 1'b1;
      @(negedge clk);
      c_start = 1'b0;
      while (l < 40) begin
         @(negedge clk);
         l++;
         if (c_done) break;
      end
      chk({tag, "_lat"}, 64'(l), 64'd8);
      chk({tag, "_bcd"}, 64'(c_bcd), ref_bcd(v, 3));
      chk({tag, "_ovf"}, 64'(c_ovf), 64'(ref_ovf(v, 3)));
`ifdef LEADING_ZERO_BLANK_EN
      chk({tag, "_blank"}, 64'(c_blank), ref_blank(v, 3));
`endif
   endtask

   initial begin
      logic [15:0] rv;

      // Reset state
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_ready", 64'(a_ready), 64'd1);
      chk("rst_done",  64'(a_done),  64'd0);
      chk("rst_bcd",   64'(a_bcd),   64'd0);
      chk("rst_ovf",   64'(a_ovf),   64'd0);
`ifdef LEADING_ZERO_BLANK_EN
      chk("rst_blank", 64'(a_blank), 64'b11110);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic conversion, ready drop, single-cycle done
      start_a(16'd1234);
      chk("c1234_busy", 64'(a_ready), 64'd0);
      wait_a(0, lat);
      check_a("c1234", 1234, lat);
      @(negedge clk);
      chk("c1234_done_pulse", 64'(a_done), 64'd0);
      chk("c1234_hold", 64'(a_bcd), 64'h01234);

      start_a(16'd65535);
      wait_a(0, lat);
      check_a("c65535", 65535, lat);
      @(negedge clk);
      start_a(16'd0);
      wait_a(0, lat);
      check_a("c0", 0, lat);
      @(negedge clk);

      // Start while busy is ignored; back-to-back start in done cycle
      start_a(16'd42);
      @(negedge clk);
      a_start = 1'b1;
      a_val   = 16'd777;
      @(negedge clk);
      a_start = 1'b0;
      chk("ign_busy", 64'(a_ready), 64'd0);
      wait_a(2, lat);
      check_a("c42", 42, lat);
      start_a(16'd500);
      chk("b2b_done_clear", 64'(a_done), 64'd0);
      chk("b2b_hold", 64'(a_bcd), 64'h00042);
      wait_a(0, lat);
      check_a("c500", 500, lat);
      @(negedge clk);

      // Reset in the middle of a conversion
      start_a(16'd999);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_bcd",   64'(a_bcd),   64'd0);
      chk("mid_rst_ovf",   64'(a_ovf),   64'd0);
      chk("mid_rst_ready", 64'(a_ready), 64'd1);
      chk("mid_rst_done",  64'(a_done),  64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (a_done) break;
      end
      chk("mid_rst_nodone", 64'(a_done), 64'd0);
      start_a(16'd321);
      wait_a(0, lat);
      check_a("c321", 321, lat);
      @(negedge clk);

      // Four-digit instance: boundary and overflow
      conv_b("b9999", 9999);
      @(negedge clk);
      conv_b("b10000", 10000);
      @(negedge clk);
      conv_b("b40000", 40000);
      @(negedge clk);
      conv_b("b0", 0);
      @(negedge clk);
      conv_b("b999", 999);
      @(negedge clk);

      // Eight-bit, three-digit instance
      conv_c("c255", 255);
      @(negedge clk);
      conv_c("c99", 99);
      @(negedge clk);

      // Randomised sweep
      for (int n = 0; n < 2000; n++) begin
         case (n % 4)
            0:       rv = 16'($urandom_range(0, 99));
            1:       rv = 16'($urandom_range(9990, 10010));
            default: rv = 16'($urandom);
         endcase
         start_a(rv);
         wait_a(0, lat);
         check_a("rnd", 64'(rv), lat);
         if (n % 50 == 0) begin
            @(negedge clk);
            conv_b("rnd_b", 64'(rv));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
